load_store_unit: RTL

//  Initiator side of the core's byte-addressed data-memory port. Accepts one

---
 rtl/load_store_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store initiator for the byte-addressed data-memory port.
// One request in flight: IDLE accepts and classifies, ACCESS drives memory for one cycle, RESP holds the result.
module load_store_unit #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_store,
  input  logic [2:0]            i_req_funct3,
  input  logic [31:0]           i_req_addr,
  input  logic [31:0]           i_req_wdata,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic [31:0]           o_resp_data,
  output logic [1:0]            o_resp_err,
  output logic                  o_mem_ren,
  output logic                  o_mem_wen,
  output logic [2:0]            o_mem_funct3,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  input  logic [31:0]           i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_FAULT = 2'd2;

  state_t                r_state;
  state_t                w_next;
  logic                  r_store;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [1:0]            r_err;

  logic                  w_accept;
  logic                  w_funct3_ok;
  logic                  w_misaligned;
  logic                  w_out_of_range;
  logic [1:0]            w_err;

  assign w_accept = (r_state == S_IDLE) && i_req_valid;

  // Illegal encodings and misalignment both report as err=1 and take precedence over range faults.
  always_comb begin
    w_funct3_ok = 1'b0;
    if (i_req_store) begin
      w_funct3_ok = (i_req_funct3 == 3'b000) || (i_req_funct3 == 3'b001) ||
                    (i_req_funct3 == 3'b010);
    end else begin
      w_funct3_ok = (i_req_funct3 == 3'b000) || (i_req_funct3 == 3'b001) ||
                    (i_req_funct3 == 3'b010) || (i_req_funct3 == 3'b100) ||
                    (i_req_funct3 == 3'b101);
    end
  end

  assign w_misaligned   = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                          ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
  assign w_out_of_range = (i_req_addr >> ADDR_WIDTH) != 32'd0;

  always_comb begin
    w_err = ERR_NONE;
    if (!w_funct3_ok || w_misaligned) begin
      w_err = ERR_ALIGN;
    end else if (w_out_of_range) begin
      w_err = ERR_FAULT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_store  <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_err    <= ERR_NONE;
    end else if (w_accept) begin
      r_store  <= i_req_store;
      r_funct3 <= i_req_funct3;
      r_addr   <= i_req_addr[ADDR_WIDTH-1:0];
      r_wdata  <= i_req_wdata;
      r_err    <= w_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Memory strobes exist only in ACCESS, so mem_rdata stays frozen while a response is held.
  always_comb begin
    w_next       = r_state;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    o_resp_data  = 32'd0;
    o_resp_err   = ERR_NONE;
    o_mem_ren    = 1'b0;
    o_mem_wen    = 1'b0;
    o_mem_funct3 = 3'd0;
    o_mem_addr   = '0;
    o_mem_wdata  = 32'd0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          w_next = (w_err != ERR_NONE) ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        o_mem_ren    = ~r_store;
        o_mem_wen    = r_store & ~rst;
        o_mem_funct3 = r_funct3;
        o_mem_addr   = r_addr;
        o_mem_wdata  = r_wdata;
        w_next       = S_RESP;
      end
      S_RESP: begin
        o_resp_valid = 1'b1;
        o_resp_err   = r_err;
        if ((r_err == ERR_NONE) && !r_store) begin
          o_resp_data = i_mem_rdata;
        end
        if (i_resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule
